// File: rtl/perfect_checker_ctrl_pkg.sv
// Shared types for the perfect-number checker: ALU op codes, FSM states and
// the per-cycle control word that drives the shared-bus datapath.
package perfect_pkg;

  localparam int unsigned FSEL_W  = 3;
  localparam int unsigned STATE_W = 4;

  localparam logic [FSEL_W-1:0] FSEL_PASS = 3'b000;
  localparam logic [FSEL_W-1:0] FSEL_ADD  = 3'b001;
  localparam logic [FSEL_W-1:0] FSEL_SUB  = 3'b010;
  localparam logic [FSEL_W-1:0] FSEL_INC  = 3'b011;
  localparam logic [FSEL_W-1:0] FSEL_ZERO = 3'b100;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 4'd0,
    LOADN   = 4'd1,
    INIT    = 4'd2,
    INC_I   = 4'd3,
    CMP     = 4'd4,
    LD_REM  = 4'd5,
    DIV     = 4'd6,
    ADD_SUM = 4'd7,
    FINAL   = 4'd8,
    DONE    = 4'd9
  } state_e;

  typedef struct packed {
    logic              tn;
    logic              ti;
    logic              tr;
    logic              ts;
    logic              tyi;
    logic              tyn;
    logic              ld_n;
    logic              ld_i;
    logic              ld_sum;
    logic              ld_rem;
    logic [FSEL_W-1:0] fselect;
  } ctrl_word_t;

  // State-only (Moore) part of the control word; DIV's conditional ldRem is added by the FSM.
  function automatic ctrl_word_t ctrl_for_state(input state_e s);
    ctrl_word_t c;
    c = '0;
    case (s)
      LOADN:   c.ld_n = 1'b1;
      INIT:    begin c.fselect = FSEL_ZERO; c.ld_i = 1'b1; c.ld_sum = 1'b1; end
      INC_I:   begin c.ti = 1'b1; c.fselect = FSEL_INC; c.ld_i = 1'b1; end
      CMP:     begin c.ti = 1'b1; c.tyn = 1'b1; c.fselect = FSEL_SUB; end
      LD_REM:  begin c.tn = 1'b1; c.fselect = FSEL_PASS; c.ld_rem = 1'b1; end
      DIV:     begin c.tr = 1'b1; c.tyi = 1'b1; c.fselect = FSEL_SUB; end
      ADD_SUM: begin c.ts = 1'b1; c.tyi = 1'b1; c.fselect = FSEL_ADD; c.ld_sum = 1'b1; end
      FINAL:   begin c.ts = 1'b1; c.tyn = 1'b1; c.fselect = FSEL_SUB; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/perfect_checker_ctrl_if.sv
// Control/status bundle between the checker FSM (master) and the
// shared-bus datapath (slave).
interface perfect_checker_ctrl_if;
  import perfect_pkg::*;

  logic              start;
  logic              bor;
  logic              zero;
  logic              TN;
  logic              TI;
  logic              TR;
  logic              TS;
  logic              TYI;
  logic              TYN;
  logic              ldN;
  logic              ldI;
  logic              ldSum;
  logic              ldRem;
  logic [FSEL_W-1:0] fselect;
  logic              busy;
  logic              done;
  logic              is_perfect;

  modport master (
    input  start, bor, zero,
    output TN, TI, TR, TS, TYI, TYN, ldN, ldI, ldSum, ldRem, fselect,
    output busy, done, is_perfect
  );

  modport slave (
    output start, bor, zero,
    input  TN, TI, TR, TS, TYI, TYN, ldN, ldI, ldSum, ldRem, fselect,
    input  busy, done, is_perfect
  );
endinterface

// File: rtl/perfect_checker_ctrl.sv
// Sequencer for the shared-bus perfect-number datapath: walks divisor
// candidates I, divides by repeated subtraction and compares SUM with N.
module perfect_checker_ctrl
  import perfect_pkg::*;
(
  input logic                    clk,
  input logic                    clr,
  perfect_checker_ctrl_if.master bus
);

  state_e     state_q, state_d;
  ctrl_word_t ctrl_q, ctrl_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       added_q, added_d;
  logic       is_perfect_q, is_perfect_d;
  logic       ld_rem_c;

  // Next state, result/flag updates and the control word of the next state.
  always_comb begin
    state_d      = state_q;
    added_d      = added_q;
    is_perfect_d = is_perfect_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOADN;
      LOADN:   state_d = INIT;
      INIT:    begin state_d = INC_I; added_d = 1'b0; end
      INC_I:   state_d = CMP;
      CMP:     state_d = bus.bor ? LD_REM : FINAL;
      LD_REM:  state_d = DIV;
      DIV: begin
        if (bus.zero)     state_d = ADD_SUM;
        else if (bus.bor) state_d = INC_I;
      end
      ADD_SUM: begin state_d = INC_I; added_d = 1'b1; end
      FINAL: begin
        state_d      = DONE;
        // Without any divisor added (N=0, N=1) the candidate is never perfect.
        is_perfect_d = bus.zero & ~bus.bor & added_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ctrl_d = ctrl_for_state(state_d);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Keep subtracting while the remainder stays positive and nonzero.
  assign ld_rem_c = (state_q == DIV) & ~bus.zero & ~bus.bor;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      ctrl_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      added_q      <= 1'b0;
      is_perfect_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      added_q      <= added_d;
      is_perfect_q <= is_perfect_d;
    end
  end

  assign bus.TN         = ctrl_q.tn;
  assign bus.TI         = ctrl_q.ti;
  assign bus.TR         = ctrl_q.tr;
  assign bus.TS         = ctrl_q.ts;
  assign bus.TYI        = ctrl_q.tyi;
  assign bus.TYN        = ctrl_q.tyn;
  assign bus.ldN        = ctrl_q.ld_n;
  assign bus.ldI        = ctrl_q.ld_i;
  assign bus.ldSum      = ctrl_q.ld_sum;
  assign bus.ldRem      = ctrl_q.ld_rem | ld_rem_c;
  assign bus.fselect    = ctrl_q.fselect;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.is_perfect = is_perfect_q;

endmodule

// File: doc/perfect_checker_ctrl.md
# perfect_checker_ctrl

Control FSM that sequences the shared-bus perfect-number datapath (N, I, SUM, REM registers, one ALU on X/Y buses) to decide whether a 16-bit operand equals the sum of its proper divisors. Divisibility uses repeated subtraction on REM, driven through the same ALU. It emits one-hot bus-driver enables, register loads and `fselect` each cycle, and consumes the ALU `bor`/`zero` status. Data-width independent; sits beside the datapath at top level.

## Interface
- Parameters: none.
- `clk` in 1: sole clock, rising edge.
- `clr` in 1: synchronous, active-high reset.
- `start` in 1: begin a check; N is loaded from the datapath's external `x` input.
- `bor` in 1: ALU borrow, 1 when X < Y on SUB (combinational, same cycle).
- `zero` in 1: ALU result Zbus == 0 (combinational, same cycle).
- `TN`, `TI`, `TR`, `TS` out 1 each: X-bus drivers N, I, REM, SUM.
- `TYI`, `TYN` out 1 each: Y-bus drivers I, N.
- `ldN`, `ldI`, `ldSum`, `ldRem` out 1 each: register loads. N loads from `x`; others load from Zbus.
- `fselect` out 3: ALU op.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the result is valid.
- `is_perfect` out 1: registered result, held until next accepted `start`.

## Operation
- ALU ops: PASS=000 (X), ADD=001, SUB=010 (X−Y), INC=011 (X+1), ZERO=100. All arithmetic is 16-bit modulo.
- States and outputs (unlisted outputs 0):
  - IDLE: `start` → LOADN.
  - LOADN: `ldN` → INIT.
  - INIT: ZERO, `ldI`, `ldSum`; clear `added` flag → INC_I.
  - INC_I: `TI`, INC, `ldI` → CMP.
  - CMP: `TI`, `TYN`, SUB. `bor`=0 (I ≥ N) → FINAL, else → LD_REM.
  - LD_REM: `TN`, PASS, `ldRem` → DIV.
  - DIV: `TR`, `TYI`, SUB. `zero` → ADD_SUM; else `bor` → INC_I; else assert `ldRem` (Mealy) and stay in DIV.
  - ADD_SUM: `TS`, `TYI`, ADD, `ldSum`; set `added` → INC_I.
  - FINAL: `TS`, `TYN`, SUB; register `is_perfect <= zero & ~bor & added` → DONE.
  - DONE: `done`=1 → IDLE.
- `added` forces N=0 and N=1 to report not-perfect.
- Bus rule: at most one of TN/TI/TR/TS and at most one of TYI/TYN high in any cycle. No enables in IDLE, LOADN, INIT or DONE.

## Timing
- Reset: state IDLE; all outputs 0, including `is_perfect`, `busy`, `done`; `added`=0. `clr` in any state aborts within one edge. Datapath `clr` is tied to the same net.
- `start` is sampled only in IDLE. It is ignored while `busy`, including in DONE. The `start` and `done` cycles never overlap.
- If `start` is sampled at edge k, LOADN occupies cycle k+1.
- Per candidate I:
  - INC_I + CMP + LD_REM = 3 cycles.
  - DIV takes N/I cycles when I divides N, otherwise ⌊N/I⌋+1 cycles.
  - ADD_SUM adds +1 when I divides N.
- Closing sequence: final INC_I + CMP, then FINAL, then DONE.
- Latency: N=0 or 1 gives `done` in cycle k+6; N=6 gives k+39.
- `is_perfect` updates on the FINAL→DONE edge; it is stable while `done`=1.
- Status inputs are used in the same cycle as the control word that produced them; there is no pipeline.

## Structure
- Shared package `perfect_pkg` holds:
  - the `fselect` constants (PASS/ADD/SUB/INC/ZERO);
  - the state enum (IDLE, LOADN, INIT, INC_I, CMP, LD_REM, DIV, ADD_SUM, FINAL, DONE).
- Single module. Structure: next-state register, one combinational output/next-state block, and registered `is_perfect`/`added`. No sub-module.

## Test plan
- Reset, then `start` with x=6: `done` in cycle k+39, `is_perfect`=1, `busy` high for cycles k+1..k+39.
- x=28: `is_perfect`=1. x=12 (sum 16): `is_perfect`=0, FINAL sees `bor`=0 and `zero`=0. x=4 (sum 3): 0, with `bor`=1.
- x=0 and x=1: `done` at k+6, `is_perfect`=0. x=2: `is_perfect`=0.
- `start` pulsed mid-run with x=6 and in the DONE cycle: ignored, result unchanged. Back-to-back runs 6 then 8: 1 then 0.
- `clr` asserted in DIV: next cycle IDLE with all outputs 0. A fresh run of x=496 then completes with `is_perfect`=1.
- Assertion every cycle: bus enables mutually one-hot per bus, and `ldRem` in DIV only when `zero`=0 and `bor`=0.
